cipher_tx_serializer: RTL and testbench

Reads the captured ASCON result (1472-bit cipher wave plus 128-bit tag) and streams it byte by byte into the UART transmitter. It is the reader counterpart of the cipher register, which writes 64-bit cipher words into the wave. It sits between the cipher register / ASCON tag output and the UART core transmit port (`Din`/`LD`/`TxBusy`), and off-loads frame serialization from the UART command FSM.

---
 rtl/cipher_tx_serializer_pkg.sv | 19 +
 rtl/cipher_tx_serializer.sv | 132 +++++++++++++
 tb/tb_cipher_tx_serializer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_tx_serializer_pkg.sv
// Shared constants and state type for the cipher frame serializer.
// Frame length depends on whether CIPHER_TX_CHECKSUM_EN is defined.
package cipher_tx_serializer_pkg;

    localparam int unsigned NDBits            = 8;
    localparam int unsigned WAVE_BYTES        = 184;
    localparam int unsigned TAG_BYTES         = 16;
    localparam int unsigned FRAME_BYTES_PLAIN = WAVE_BYTES + TAG_BYTES;
    localparam int unsigned FRAME_BYTES_CSUM  = WAVE_BYTES + TAG_BYTES + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } cipher_tx_state_t;

endpackage

// File: rtl/cipher_tx_serializer.sv
// Streams the snapshotted {wave, tag} frame MSB byte first into the UART transmit port.
// Define CIPHER_TX_CHECKSUM_EN to append an XOR checksum byte after the tag.
module cipher_tx_serializer #(
    parameter int unsigned WAVE_BYTES = cipher_tx_serializer_pkg::WAVE_BYTES,
    parameter int unsigned TAG_BYTES  = cipher_tx_serializer_pkg::TAG_BYTES
) (
    input  logic                                             clock_i,
    input  logic                                             resetb_i,
    input  logic                                             start_i,
    input  logic [WAVE_BYTES*cipher_tx_serializer_pkg::NDBits-1:0] wave_i,
    input  logic [TAG_BYTES*cipher_tx_serializer_pkg::NDBits-1:0]  tag_i,
    input  logic                                             tx_busy_i,
    output logic [cipher_tx_serializer_pkg::NDBits-1:0]      tx_byte_o,
    output logic                                             load_o,
    output logic                                             busy_o,
    output logic                                             done_o
);
    import cipher_tx_serializer_pkg::*;

    localparam int unsigned PAY_BYTES = WAVE_BYTES + TAG_BYTES;
    localparam int unsigned PAY_BITS  = PAY_BYTES * NDBits;
`ifdef CIPHER_TX_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = PAY_BYTES + 1;
`else
    localparam int unsigned FRAME_BYTES = PAY_BYTES;
`endif
    localparam int unsigned SR_BITS  = FRAME_BYTES * NDBits;
    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    cipher_tx_state_t    r_state;
    logic [SR_BITS-1:0]  r_sr;
    logic [CNT_W-1:0]    r_cnt;
    logic [NDBits-1:0]   r_byte;
    logic                r_load;
    logic                r_busy;
    logic                r_done;

    logic [PAY_BITS-1:0] w_payload;
    logic [SR_BITS-1:0]  w_snapshot;

    assign w_payload = {wave_i, tag_i};

`ifdef CIPHER_TX_CHECKSUM_EN
    logic [NDBits-1:0] w_csum;

    // XOR of every payload byte, folded into the snapshot at start
    always_comb begin
        w_csum = '0;
        for (int unsigned i = 0; i < PAY_BYTES; i++) begin
            w_csum = w_csum ^ w_payload[i*NDBits +: NDBits];
        end
    end

    assign w_snapshot = {w_payload, w_csum};
`else
    assign w_snapshot = w_payload;
`endif

    // The strobe is issued from whichever state sees the UART idle, so the
    // first load lands one cycle after start and each next load one cycle
    // after tx_busy_i falls.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_sr   <= w_snapshot;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (!tx_busy_i) begin
                            r_load  <= 1'b1;
                            r_byte  <= w_snapshot[SR_BITS-1 -: NDBits];
                            r_state <= ST_WAIT_HI;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (!tx_busy_i) begin
                        r_load  <= 1'b1;
                        r_byte  <= r_sr[SR_BITS-1 -: NDBits];
                        r_state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (tx_busy_i) begin
                        r_sr    <= r_sr << NDBits;
                        r_state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy_i) begin
                        if (r_cnt == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_load  <= 1'b1;
                            r_byte  <= r_sr[SR_BITS-1 -: NDBits];
                            r_state <= ST_WAIT_HI;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_byte_o = r_byte;
    assign load_o    = r_load;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule

// File: tb/tb_cipher_tx_serializer.sv
// Randomized bench for cipher_tx_serializer against a byte-queue frame model.
// Honours CIPHER_TX_CHECKSUM_EN for the expected frame length and checksum byte.
`timescale 1ns/1ps
module tb_cipher_tx_serializer;

    localparam int unsigned WB = 184;
    localparam int unsigned TB = 16;
    localparam int unsigned PB = WB + TB;
`ifdef CIPHER_TX_CHECKSUM_EN
    localparam int unsigned FLEN = PB + 1;
`else
    localparam int unsigned FLEN = PB;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [1471:0] wave     = '0;
    logic [127:0]  tag      = '0;
    logic          tx_busy  = 1'b0;
    logic [7:0]    tx_byte;
    logic          load;
    logic          busy;
    logic          done;

    int n_cmp    = 0;
    int n_bad    = 0;
    int idx      = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int fall_cyc = -10;
    bit armed    = 1'b0;
    logic prev_busy = 1'b0;
    logic [7:0] exp_b [FLEN];
    logic [7:0] rx_b  [FLEN];
    logic [1599:0] m_flat;
    logic [7:0]    m_x;

    int rise_dly   = 1;
    int hold_cyc   = 10;
    bit force_busy = 1'b0;
    int u_rise     = 0;
    int u_hold     = 0;

    cipher_tx_serializer dut (
        .clock_i  (clk),
        .resetb_i (rst_n),
        .start_i  (start),
        .wave_i   (wave),
        .tag_i    (tag),
        .tx_busy_i(tx_busy),
        .tx_byte_o(tx_byte),
        .load_o   (load),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART model: busy rises rise_dly cycles after a strobe and stays high hold_cyc cycles
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            u_rise = 0;
            u_hold = 0;
        end else begin
            if (u_rise > 0) begin
                u_rise--;
                if (u_rise == 0) u_hold = hold_cyc;
            end else if (u_hold > 0) begin
                u_hold--;
            end
            if (load) u_rise = rise_dly;
        end
        tx_busy = force_busy || (u_rise == 0 && u_hold > 0);
    end

    // Frame model and per-cycle compare
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("reset_outputs", 32'({tx_byte, load, busy, done}), 32'h0);
            armed = 1'b0;
            idx   = 0;
        end else begin
            if (load) begin
                check("load_uart_idle", 32'(prev_busy), 32'h0);
                check("load_busy_high", 32'(busy), 32'h1);
                check("load_in_frame", 32'(armed && idx < int'(FLEN)), 32'h1);
                if (armed && idx < int'(FLEN)) begin
                    check($sformatf("byte[%0d]", idx), 32'(tx_byte), 32'(exp_b[idx]));
                    rx_b[idx] = tx_byte;
                end
                idx++;
            end
            if (done) begin
                check("done_in_frame", 32'(armed), 32'h1);
                check("done_busy_low", 32'(busy), 32'h0);
                check("done_byte_count", 32'(idx), 32'(FLEN));
                check("done_latency", 32'(cyc - fall_cyc), 32'h1);
                done_cnt++;
                armed = 1'b0;
            end else begin
                check("busy_level", 32'(busy), 32'(armed));
            end
            if (start && !armed) begin
                m_flat = {wave, tag};
                for (int i = 0; i < int'(PB); i++) exp_b[i] = m_flat[1599 - 8*i -: 8];
`ifdef CIPHER_TX_CHECKSUM_EN
                m_x = 8'h00;
                for (int i = 0; i < int'(PB); i++) m_x = m_x ^ exp_b[i];
                exp_b[PB] = m_x;
`endif
                armed = 1'b1;
                idx   = 0;
            end
        end
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick(1);
            k++;
        end
        check("frame_completed", 32'(done_cnt != d0), 32'h1);
        tick(1);
        check("idle_after_done", 32'({busy, done, load}), 32'h0);
    endtask

    task automatic wait_idx(input int target, input int budget);
        int k = 0;
        while (idx < target && k < budget) begin
            tick(1);
            k++;
        end
        check("reached_byte", 32'(idx >= target), 32'h1);
    endtask

    task automatic set_ascending();
        for (int i = 0; i < int'(WB); i++) wave[1471 - 8*i -: 8] = 8'(i);
        for (int i = 0; i < int'(TB); i++) tag[127 - 8*i -: 8] = 8'(8'hF0 + i);
    endtask

    task automatic set_random();
        for (int i = 0; i < 46; i++) wave[32*i +: 32] = $urandom;
        for (int i = 0; i < 4; i++) tag[32*i +: 32] = $urandom;
    endtask

    task automatic run_frame(input int rise, input int hold);
        rise_dly = rise;
        hold_cyc = hold;
        pulse_start();
        wait_done(int'(FLEN) * (rise + hold + 6) + 100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_tx_byte", 32'(tx_byte), 32'h0);
        check("rst_load", 32'(load), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick(3);

        // ascending frame, UART busy 10 cycles per byte
        set_ascending();
        rise_dly = 1;
        hold_cyc = 10;
        pulse_start();
        check("first_load_n1", 32'(load), 32'h1);
        check("first_busy_n1", 32'(busy), 32'h1);
        wait_done(int'(FLEN) * 20 + 100);
        check("lit_byte0", 32'(rx_b[0]), 32'h00);
        check("lit_byte99", 32'(rx_b[99]), 32'h63);
        check("lit_byte183", 32'(rx_b[183]), 32'hB7);
        check("lit_byte184", 32'(rx_b[184]), 32'hF0);
        check("lit_byte199", 32'(rx_b[199]), 32'hFF);
        tick(5);

        // all 0xA5 except last tag byte 0x5A
        for (int i = 0; i < int'(WB); i++) wave[1471 - 8*i -: 8] = 8'hA5;
        for (int i = 0; i < int'(TB); i++) tag[127 - 8*i -: 8] = 8'hA5;
        tag[7:0] = 8'h5A;
        run_frame(1, 4);
        check("lit_a5_first", 32'(rx_b[0]), 32'hA5);
        check("lit_a5_last_tag", 32'(rx_b[199]), 32'h5A);
`ifdef CIPHER_TX_CHECKSUM_EN
        check("lit_checksum", 32'(rx_b[200]), 32'hFF);
`endif
        tick(5);

        // second start mid-frame with new data must be ignored
        set_random();
        rise_dly = 1;
        hold_cyc = 3;
        pulse_start();
        wait_idx(50, 3000);
        set_random();
        pulse_start();
        wait_done(int'(FLEN) * 12 + 100);
        tick(20);
        check("no_queued_frame", 32'({busy, load}), 32'h0);
        tick(5);

        // UART busy held high for 30 cycles around start
        set_random();
        force_busy = 1'b1;
        tick(2);
        rise_dly = 2;
        hold_cyc = 3;
        pulse_start();
        tick(30);
        check("held_no_load", 32'(idx), 32'h0);
        check("held_busy_o", 32'(busy), 32'h1);
        force_busy = 1'b0;
        wait_done(int'(FLEN) * 12 + 100);
        tick(5);

        // reset mid-frame, then a full fresh frame
        set_random();
        rise_dly = 1;
        hold_cyc = 2;
        pulse_start();
        wait_idx(101, 3000);
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", 32'({tx_byte, load, busy, done}), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("no_load_after_reset", 32'(idx), 32'h0);
        set_random();
        run_frame(1, 2);
        tick(5);

        // slow UART acceptance: busy rises 5 cycles after the strobe
        set_random();
        run_frame(5, 3);
        tick(5);

        // random UART timing
        for (int f = 0; f < 2; f++) begin
            set_random();
            run_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 8)));
            tick(int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
